// File: rtl/b16_mem_resp.sv
// b16 bus memory responder: word RAM, byte-lane writes, fixed wait states.
// Define PARITY_EN for per-byte even parity and the sticky perr output.
module b16_mem_resp #(
  parameter int unsigned  l     = 16,
  parameter int unsigned  adep  = 10,
  parameter logic [l-1:0] base  = '0,
  parameter int unsigned  waits = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [l-1:0] addr,
  input  logic         rd,
  input  logic [1:0]   wr,
  input  logic [l-1:0] din,
  output logic [l-1:0] data,
  output logic         READY,
  output logic         sel
`ifdef PARITY_EN
  ,
  output logic         perr
`endif
);

  localparam int unsigned DEPTH = 1 << adep;
  localparam int unsigned KW    = l + 2;
  localparam logic [3:0]  CNT_INIT =
    (waits == 0) ? 4'd0 : 4'(waits - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [KW-1:0] key_q, key_d;
  logic          ready_q, ready_d;
  logic [l-1:0]  data_q;
  logic [l-1:0]  mem_q [DEPTH];

  logic [KW-1:0]   key;
  logic [adep-1:0] idx;
  logic            req;
  logic            start;
  logic            do_acc;
  logic            do_rd;
  logic            we;
  logic            unused_addr0;

  assign sel   = (addr[l-1:adep+1] == base[l-1:adep+1]);
  assign req   = sel & (rd | (|wr));
  assign key   = {addr[l-1:1], rd, wr};
  assign idx   = addr[adep:1];
  assign do_rd = do_acc & (wr == 2'b00);
  assign we    = do_acc & reset;
  assign unused_addr0 = addr[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    ready_d = ready_q;
    start   = 1'b0;
    do_acc  = 1'b0;
    unique case (state_q)
      IDLE: start = req;
      WAIT: begin
        if (!req || key != key_q) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_acc  = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end else if (key != key_q) begin
          start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new key out of DONE restarts on this same edge
    if (start) begin
      key_d = key;
      if (waits == 0) begin
        do_acc  = 1'b1;
        ready_d = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d   = CNT_INIT;
        ready_d = 1'b0;
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      if (do_rd) begin
        data_q <= mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && wr[1]) begin
      mem_q[idx][15:8] <= din[15:8];
    end
    if (we && wr[0]) begin
      mem_q[idx][7:0] <= din[7:0];
    end
  end

`ifdef PARITY_EN
  logic [1:0] par_q [DEPTH];
  logic       perr_q;
  logic [1:0] par_rd;

  assign par_rd = {^mem_q[idx][15:8], ^mem_q[idx][7:0]};

  always_ff @(posedge clk) begin
    if (we && wr[1]) begin
      par_q[idx][1] <= ^din[15:8];
    end
    if (we && wr[0]) begin
      par_q[idx][0] <= ^din[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (do_rd && par_rd != par_q[idx]) begin
      perr_q <= 1'b1;
    end
  end

  assign perr = perr_q;
`endif

  assign data  = data_q;
  assign READY = ready_q;

endmodule
